// File: rtl/ifq_pkg.sv
// Shared fetch-queue types: widths, opcode encoding, queue entry.
// Also holds the saturating adder used by the IFQ_PERF_EN counters.
package ifq_pkg;

   localparam int IFQ_ADDR_W = 4;
   localparam int IFQ_DATA_W = 8;
   localparam int IFQ_DEPTH  = 4;

   typedef enum logic [1:0] {
      OP_LOAD  = 2'b00,
      OP_ADD   = 2'b01,
      OP_STORE = 2'b10,
      OP_JUMP  = 2'b11
   } opcode_e;

   typedef struct packed {
      logic [IFQ_ADDR_W-1:0] pc;
      logic [IFQ_DATA_W-1:0] instr;
   } ifq_entry_t;

   function automatic opcode_e opcode_of(
      input logic [IFQ_DATA_W-1:0] i
   );
      return opcode_e'(i[7:6]);
   endfunction

   function automatic logic [15:0] sat_add16(
      input logic [15:0] a,
      input logic [15:0] b
   );
      logic [16:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[16] ? 16'hFFFF : s[15:0];
   endfunction

endpackage

// File: rtl/instr_fetch_queue_if.sv
// Fetch-stage bus: instruction memory port, decode handshake, redirect.
// master = fetch queue, slave = memory/decode side.
interface instr_fetch_queue_if
   import ifq_pkg::*;
#(
   parameter int ADDR_W = IFQ_ADDR_W,
   parameter int DATA_W = IFQ_DATA_W
);

   logic              imem_en;
   logic [ADDR_W-1:0] imem_addr;
   logic [DATA_W-1:0] imem_rdata;
   logic              instr_valid;
   logic              instr_ready;
   logic [DATA_W-1:0] instr;
   logic [ADDR_W-1:0] instr_pc;
   logic              redirect_valid;
   logic [ADDR_W-1:0] redirect_pc;

   modport master (
      output imem_en,
      output imem_addr,
      input  imem_rdata,
      output instr_valid,
      input  instr_ready,
      output instr,
      output instr_pc,
      input  redirect_valid,
      input  redirect_pc
   );

   modport slave (
      input  imem_en,
      input  imem_addr,
      output imem_rdata,
      input  instr_valid,
      output instr_ready,
      input  instr,
      input  instr_pc,
      output redirect_valid,
      output redirect_pc
   );

endinterface

// File: rtl/ifq_fifo.sv
// Small synchronous FIFO of fetched {pc, instr} entries.
// Flush wins over push; storage is cleared on reset so head reads zero.
module ifq_fifo
   import ifq_pkg::*;
#(
   parameter int DEPTH = IFQ_DEPTH
)(
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push,
   input  ifq_entry_t             din,
   input  logic                   pop,
   input  logic                   flush,
   output logic [$clog2(DEPTH):0] count,
   output ifq_entry_t             head
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   ifq_entry_t    mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign do_pop  = pop && (count != '0);
   assign do_push = push &&
                    ((count != CW'(DEPTH)) || do_pop);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++)
            mem[i] <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + PW'(1);
         end
         if (do_pop)
            rd_ptr <= rd_ptr + PW'(1);
         count <= count + CW'(do_push)
                        - CW'(do_pop);
      end
   end

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch stage: issues imem reads, queues returns, serves decode, handles jumps.
// Define IFQ_PERF_EN to add the perf_fetched / perf_flushed counters.
module instr_fetch_queue
   import ifq_pkg::*;
#(
   parameter int ADDR_W = IFQ_ADDR_W,
   parameter int DATA_W = IFQ_DATA_W,
   parameter int DEPTH  = IFQ_DEPTH
)(
   input  logic        clk,
   input  logic        reset,
`ifdef IFQ_PERF_EN
   output logic [15:0] perf_fetched,
   output logic [15:0] perf_flushed,
`endif
   instr_fetch_queue_if.master bus
);

   localparam int CW = $clog2(DEPTH) + 1;

   logic [ADDR_W-1:0] fetch_pc;
   logic [ADDR_W-1:0] inflight_pc;
   logic              inflight;
   logic [CW-1:0]     count;
   logic [CW-1:0]     occupied;
   ifq_entry_t        head;
   ifq_entry_t        din;
   logic              issue;
   logic              push;
   logic              pop;
   logic              flush;
   logic              valid;

   // Free space ignores a same-cycle pop; reset gates the strobe low.
   always_comb begin
      flush    = bus.redirect_valid;
      valid    = (count != '0);
      pop      = valid && bus.instr_ready;
      occupied = count + CW'(inflight);
      issue    = reset && !flush &&
                 (occupied < CW'(DEPTH));
      push     = inflight && !flush;
      din      = '{pc: inflight_pc,
                   instr: bus.imem_rdata};
   end

   assign bus.imem_en     = issue;
   assign bus.imem_addr   = fetch_pc;
   assign bus.instr_valid = valid;
   assign bus.instr       = head.instr;
   assign bus.instr_pc    = head.pc;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fetch_pc    <= '0;
         inflight    <= 1'b0;
         inflight_pc <= '0;
      end else begin
         inflight    <= issue;
         inflight_pc <= fetch_pc;
         if (flush)
            fetch_pc <= bus.redirect_pc;
         else if (issue)
            fetch_pc <= fetch_pc + ADDR_W'(1);
      end
   end

   ifq_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .din   (din),
      .pop   (pop),
      .flush (flush),
      .count (count),
      .head  (head)
   );

`ifdef IFQ_PERF_EN
   logic [CW-1:0] discard;

   // The head accepted in a redirect cycle is consumed, not discarded.
   assign discard = occupied - CW'(pop);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         perf_fetched <= '0;
         perf_flushed <= '0;
      end else begin
         perf_fetched <= sat_add16(perf_fetched,
                                   16'(pop));
         if (flush)
            perf_flushed <= sat_add16(perf_flushed,
                                      16'(discard));
      end
   end
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue: per-cycle vector tables
// plus hand sequences for mid-stream reset and perf counters.
module tb_instr_fetch_queue;
   import ifq_pkg::*;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   instr_fetch_queue_if #(
      .ADDR_W (IFQ_ADDR_W),
      .DATA_W (IFQ_DATA_W)
   ) bus ();

`ifdef IFQ_PERF_EN
   logic [15:0] perf_fetched;
   logic [15:0] perf_flushed;
`endif

   instr_fetch_queue dut (
      .clk          (clk),
      .reset        (reset),
`ifdef IFQ_PERF_EN
      .perf_fetched (perf_fetched),
      .perf_flushed (perf_flushed),
`endif
      .bus          (bus)
   );

   logic [7:0] mem [16];

   always @(posedge clk)
      if (bus.imem_en)
         bus.imem_rdata <= mem[bus.imem_addr];

   typedef struct {
      logic       ready;
      logic       rv;
      logic [3:0] rpc;
      logic       ev;
      logic [3:0] epc;
      logic       een;
      logic [3:0] eaddr;
   } vec_t;

   vec_t vq[$];
   int   errors = 0;
   int   checks = 0;

   task automatic check(input string name,
                        input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d",
                  name, act, exp);
      end
   endtask

   task automatic add(input logic r, input logic rv,
                      input int rpc, input logic ev,
                      input int epc, input logic een,
                      input int ea);
      vec_t v;
      v.ready = r;
      v.rv    = rv;
      v.rpc   = 4'(rpc);
      v.ev    = ev;
      v.epc   = 4'(epc);
      v.een   = een;
      v.eaddr = 4'(ea);
      vq.push_back(v);
   endtask

   // Called at a negedge; returns at the negedge after the last vector.
   task automatic run(input string tag);
      foreach (vq[i]) begin
         bus.instr_ready    = vq[i].ready;
         bus.redirect_valid = vq[i].rv;
         bus.redirect_pc    = vq[i].rpc;
         #1;
         check($sformatf("%s[%0d].valid", tag, i),
               32'(bus.instr_valid), 32'(vq[i].ev));
         check($sformatf("%s[%0d].imem_en", tag, i),
               32'(bus.imem_en), 32'(vq[i].een));
         if (vq[i].een)
            check($sformatf("%s[%0d].imem_addr", tag, i),
                  32'(bus.imem_addr), 32'(vq[i].eaddr));
         if (vq[i].ev) begin
            check($sformatf("%s[%0d].instr_pc", tag, i),
                  32'(bus.instr_pc), 32'(vq[i].epc));
            check($sformatf("%s[%0d].instr", tag, i),
                  32'(bus.instr), 32'(mem[vq[i].epc]));
         end
         @(negedge clk);
      end
      bus.redirect_valid = 1'b0;
      vq.delete();
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, ".valid"}, 32'(bus.instr_valid), 0);
      check({tag, ".imem_en"}, 32'(bus.imem_en), 0);
      check({tag, ".imem_addr"}, 32'(bus.imem_addr), 0);
      check({tag, ".instr"}, 32'(bus.instr), 0);
      check({tag, ".instr_pc"}, 32'(bus.instr_pc), 0);
`ifdef IFQ_PERF_EN
      check({tag, ".perf_fetched"}, 32'(perf_fetched), 0);
      check({tag, ".perf_flushed"}, 32'(perf_flushed), 0);
`endif
   endtask

   initial begin
      for (int i = 0; i < 16; i++)
         mem[i] = 8'(i * 13 + 5);
      reset              = 1'b0;
      bus.instr_ready    = 1'b1;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = '0;
      bus.imem_rdata     = '0;

      repeat (3) @(negedge clk);
      #1;
      check_reset_state("por");
      @(negedge clk);
      reset = 1'b1;

      // Streaming with wrap, a 10-cycle stall, drain, then refill to full.
      for (int k = 0; k < 2; k++)
         add(1, 0, 0, 0, 0, 1, k);
      for (int k = 2; k < 19; k++)
         add(1, 0, 0, 1, (k - 2) % 16, 1, k % 16);
      add(0, 0, 0, 1, 1, 1, 3);
      add(0, 0, 0, 1, 1, 1, 4);
      for (int k = 21; k < 29; k++)
         add(0, 0, 0, 1, 1, 0, 0);
      add(1, 0, 0, 1, 1, 0, 0);
      for (int k = 30; k < 34; k++)
         add(1, 0, 0, 1, k - 28, 1, k - 25);
      add(0, 0, 0, 1, 6, 1, 9);
      add(0, 0, 0, 1, 6, 0, 0);
      add(0, 0, 0, 1, 6, 0, 0);
      run("stream");

      // Queue is full; reset takes effect without waiting for an edge.
      #2;
      reset = 1'b0;
      #1;
      check_reset_state("midrst");
      @(negedge clk);
      @(negedge clk);
      bus.instr_ready = 1'b1;
      reset = 1'b1;

      // Fill, pop 0/1, redirect to 9 with pcs 2..4 queued and 5 in flight.
      add(0, 0, 0, 0, 0, 1, 0);
      add(0, 0, 0, 0, 0, 1, 1);
      add(0, 0, 0, 1, 0, 1, 2);
      add(0, 0, 0, 1, 0, 1, 3);
      add(0, 0, 0, 1, 0, 0, 0);
      add(1, 0, 0, 1, 0, 0, 0);
      add(1, 0, 0, 1, 1, 1, 4);
      add(0, 0, 0, 1, 2, 1, 5);
      add(0, 1, 9, 1, 2, 0, 0);
      add(1, 0, 0, 0, 0, 1, 9);
      run("redir9");

`ifdef IFQ_PERF_EN
      check("perf.flushed_a", 32'(perf_flushed), 4);
      check("perf.fetched_a", 32'(perf_fetched), 2);
`endif

      // Redirects coinciding with pops, then back-to-back with wrap.
      add(1, 0, 0, 0, 0, 1, 10);
      add(1, 0, 0, 1, 9, 1, 11);
      add(1, 1, 1, 1, 10, 0, 0);
      add(1, 0, 0, 0, 0, 1, 1);
      add(1, 0, 0, 0, 0, 1, 2);
      add(1, 0, 0, 1, 1, 1, 3);
      add(1, 0, 0, 1, 2, 1, 4);
      add(1, 1, 12, 1, 3, 0, 0);
      add(1, 0, 0, 0, 0, 1, 12);
      add(1, 0, 0, 0, 0, 1, 13);
      add(1, 0, 0, 1, 12, 1, 14);
      add(1, 1, 6, 1, 13, 0, 0);
      add(1, 1, 14, 0, 0, 0, 0);
      add(1, 0, 0, 0, 0, 1, 14);
      add(1, 0, 0, 0, 0, 1, 15);
      add(1, 0, 0, 1, 14, 1, 0);
      add(1, 0, 0, 1, 15, 1, 1);
      add(1, 0, 0, 1, 0, 1, 2);
      run("redirpop");

`ifdef IFQ_PERF_EN
      check("perf.flushed_b", 32'(perf_flushed), 7);
      check("perf.fetched_b", 32'(perf_fetched), 12);
`endif

      $display("Result: errors=%0d of %0d checks",
               errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule
